// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-port unified memory between the instruction-fetch (IF)
// port and the data (MEM-stage) port of the pipelined core. Accesses are
// serialised. Each granted access holds the memory for MEM_LATENCY cycles.
// One DONE cycle follows, in which the winner's done output pulses.
//
// Arbitration:
//   default        fixed priority, data port wins over IF (older instruction)
//   ARB_RR_EN      round-robin: on a simultaneous request the port that was
//                  not granted last wins; a single requester always wins
//
// Parameters:
//   MEM_LATENCY    cycles the memory needs with mem_en/address stable (1..15)
//   ADDR_WIDTH     byte-address width, passed through unmodified
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   if_req/if_addr      fetch request (held until if_done) and address
//   if_done/if_rdata    one-cycle completion pulse, registered fetch data
//   if_stall            if_req & ~if_done
//   d_req/d_we/d_addr/d_wdata  data request, write enable, address, write data
//   d_done/d_rdata      one-cycle completion pulse, registered read data
//   d_stall             d_req & ~d_done
//   mem_en/mem_we       memory access strobe and write enable
//   mem_addr/mem_wdata  latched access address and write data
//   mem_rdata           memory read data, valid in the last BUSY cycle
//   conflict_cnt        saturating count of IDLE cycles with both ports requesting
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_rdata,
  output logic                  if_stall,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_done,
  output logic [31:0]           d_rdata,
  output logic                  d_stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic [15:0]           conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic        grant_d;     // current access belongs to the data port
  logic        we_q;        // latched write enable of the current access
  logic [15:0] conflict_q;
  logic        pick_d;      // arbitration result for this IDLE cycle
  logic        any_req;

  assign any_req      = if_req | d_req;
  assign conflict_cnt = conflict_q;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef ARB_RR_EN
  logic last_d;             // last grant went to the data port

  // Port not granted last wins a tie; a lone requester always wins.
  always_comb begin
    pick_d = d_req & (~if_req | ~last_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_d <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_d <= pick_d;
    end
  end
`else
  always_comb begin
    pick_d = d_req;
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = BUSY;
      BUSY:    if (cnt == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from state so reset drops them immediately)
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    if_done = 1'b0;
    d_done  = 1'b0;
    case (state)
      BUSY: begin
        mem_en = 1'b1;
        mem_we = we_q;
      end
      DONE: begin
        if_done = ~grant_d;
        d_done  = grant_d;
      end
      default: ;
    endcase
  end

  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_req & ~d_done;

  // ---------------------------------------------------------------------------
  // Datapath: grant latches, latency counter, read-data capture, conflict count
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      grant_d    <= 1'b0;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      conflict_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req && d_req && conflict_q != 16'hFFFF) begin
            conflict_q <= conflict_q + 16'd1;
          end
          if (any_req) begin
            grant_d  <= pick_d;
            we_q     <= pick_d & d_we;
            mem_addr <= pick_d ? d_addr : if_addr;
            if (pick_d) begin
              mem_wdata <= d_wdata;
            end
            cnt <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (grant_d) begin
            // Data-port writes leave d_rdata untouched.
            if (!we_q) begin
              d_rdata <= mem_rdata;
            end
          end else begin
            if_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Drivers issue fetch/data accesses and push the expected response into
// per-port queues. A transaction-level model tracks when the shared memory is
// free, who wins each grant and what was latched. A negedge monitor pops the
// queues when a done pulse appears and compares every output each cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.MEM_LATENCY(L), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  // ---------------------------------------------------------------------------
  // Memory contents: unwritten words follow a fixed pattern; the reset-vector
  // word holds the instruction used by the directed fetch.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  logic [31:0] store    [logic [31:0]];   // memory behind the arbiter
  logic [31:0] d_shadow [logic [31:0]];   // what the data port has written

  function automatic logic [31:0] d_expect_read(input logic [31:0] a);
    if (d_shadow.exists(a)) return d_shadow[a];
    return init_word(a);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) store[mem_addr] = mem_wdata;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      mem_rdata = store.exists(mem_addr) ? store[mem_addr] : init_word(mem_addr);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard queues
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        is_write;
    logic [31:0] rdata;
  } d_exp_t;

  logic [31:0] if_q[$];
  d_exp_t      d_q[$];
  logic        done_order[$];   // 0 = IF, 1 = data, in completion order

  // ---------------------------------------------------------------------------
  // Reference model: the memory is a single server. A grant can happen at any
  // edge at or after free_edge; it occupies L busy cycles plus one done cycle,
  // after which one idle cycle must pass before the next grant edge.
  // ---------------------------------------------------------------------------
  int          m_edge = 0;
  int          m_free = 0;
  int          m_g_edge = 0;
  bit          m_gv = 0;
  bit          m_g_d = 0;
  bit          m_g_we = 0;
  logic [31:0] m_g_addr = '0;
  logic [31:0] m_g_wdata = '0;
  bit          m_last_d = 0;
  logic [31:0] m_cc = '0;

  initial begin
    bit win;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_gv = 0; m_g_d = 0; m_g_we = 0; m_g_addr = '0; m_g_wdata = '0;
        m_free = 0; m_last_d = 0; m_cc = '0;
      end else begin
        m_edge++;
        if (m_edge >= m_free && (if_req || d_req)) begin
          if (if_req && d_req && m_cc < 32'd65535) m_cc = m_cc + 1;
          if (!if_req)     win = 1;
          else if (!d_req) win = 0;
          else begin
`ifdef ARB_RR_EN
            win = !m_last_d;
`else
            win = 1;
`endif
          end
          m_last_d = win;
          m_gv     = 1;
          m_g_edge = m_edge;
          m_g_d    = win;
          m_g_we   = win && d_we;
          m_g_addr = win ? d_addr : if_addr;
          if (win) m_g_wdata = d_wdata;
          m_free   = m_edge + L + 2;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata  = '0;
  bit          cc_chk = 1;
  int          mem_we_cycles = 0;

  initial begin
    bit     busy, done;
    d_exp_t de;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
      end
      busy = m_gv && (m_edge >= m_g_edge) && (m_edge < m_g_edge + L);
      done = m_gv && (m_edge == m_g_edge + L);
      if (mem_we) mem_we_cycles++;
      if (if_done) begin
        done_order.push_back(1'b0);
        if (if_q.size() == 0) check1("if_done_unexpected", if_done, 1'b0);
        else exp_if_rdata = if_q.pop_front();
      end
      if (d_done) begin
        done_order.push_back(1'b1);
        if (d_q.size() == 0) check1("d_done_unexpected", d_done, 1'b0);
        else begin
          de = d_q.pop_front();
          if (!de.is_write) exp_d_rdata = de.rdata;
        end
      end
      check1("mem_en",   mem_en,   busy);
      check1("mem_we",   mem_we,   busy && m_g_we);
      check ("mem_addr", mem_addr, m_g_addr);
      check ("mem_wdata", mem_wdata, m_g_wdata);
      check1("if_done",  if_done,  done && !m_g_d);
      check1("d_done",   d_done,   done && m_g_d);
      check1("if_stall", if_stall, if_req && !(done && !m_g_d));
      check1("d_stall",  d_stall,  d_req && !(done && m_g_d));
      check ("if_rdata", if_rdata, exp_if_rdata);
      check ("d_rdata",  d_rdata,  exp_d_rdata);
      if (cc_chk) check("conflict_cnt", {16'h0, conflict_cnt}, m_cc);
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers (called at posedge+1, return at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic if_access(input logic [31:0] a);
    int k;
    if_addr = a;
    if_req  = 1'b1;
    if_q.push_back(init_word(a));
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!if_done && k < 200);
    check1("if_timeout", if_done, 1'b1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic d_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input bit scramble);
    int     k;
    d_exp_t e;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    e.is_write = we;
    e.rdata    = we ? 32'h0 : d_expect_read(a);
    d_q.push_back(e);
    if (we) d_shadow[a] = wd;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      // Inputs changed after the grant edge must not reach the memory.
      if (scramble && k == 1) begin
        d_addr  = ~a;
        d_wdata = ~wd;
      end
    end while (!d_done && k < 200);
    check1("d_timeout", d_done, 1'b1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_if_addr();
    return 32'h0040_0000 | (32'($urandom_range(0, 255)) << 2);
  endfunction

  function automatic logic [31:0] rand_d_addr();
    return 32'h1001_0000 | (32'($urandom_range(0, 7)) << 2);
  endfunction

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] saved;
    int          we0;
    int          cc0;
    logic        exp_first;
    logic        exp_seq [4];

    // Reset state
    #2;
    check1("rst_mem_en",  mem_en,  1'b0);
    check1("rst_mem_we",  mem_we,  1'b0);
    check1("rst_if_done", if_done, 1'b0);
    check1("rst_d_done",  d_done,  1'b0);
    check ("rst_if_rdata", if_rdata, 32'h0);
    check ("rst_d_rdata",  d_rdata,  32'h0);
    check ("rst_mem_addr", mem_addr, 32'h0);
    check ("rst_conflict", {16'h0, conflict_cnt}, 32'h0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Single fetch of the reset-vector instruction
    if_access(32'h0040_0000);
    check("fetch_rdata", if_rdata, 32'h2008_0005);

    // Data write; address/data are disturbed during BUSY
    saved = d_rdata;
    we0   = mem_we_cycles;
    d_access(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 1'b1);
    check("write_we_cycles", 32'(mem_we_cycles - we0), 32'(L));
    check("write_d_rdata_held", d_rdata, saved);
    check("write_stored", store[32'h1001_0004], 32'hDEAD_BEEF);

    // Simultaneous requests: one conflict cycle, winner per arbitration rule
    done_order.delete();
    cc0 = int'(conflict_cnt);
`ifdef ARB_RR_EN
    exp_first = 1'b0;   // data was granted last
`else
    exp_first = 1'b1;
`endif
    fork
      if_access(32'h0040_0010);
      d_access(1'b0, 32'h1001_0004, 32'h0, 1'b0);
    join
    check("simul_conflict", {16'h0, conflict_cnt}, 32'(cc0 + 1));
    check("simul_done_count", 32'(done_order.size()), 32'd2);
    if (done_order.size() > 0) check1("simul_first_winner", done_order[0], exp_first);
    check("simul_read_back", d_rdata, 32'hDEAD_BEEF);

    // Both ports re-requesting back-to-back
    done_order.delete();
`ifdef ARB_RR_EN
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_seq = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
    fork
      repeat (2) if_access(rand_if_addr());
      repeat (2) d_access(1'b0, rand_d_addr(), 32'h0, 1'b0);
    join
    check("held_done_count", 32'(done_order.size()), 32'd4);
    for (int i = 0; i < 4 && i < done_order.size(); i++) begin
      check1($sformatf("held_order_%0d", i), done_order[i], exp_seq[i]);
    end

    // Reset in the second BUSY cycle of a data write
    fork
      d_access(1'b1, 32'h1001_0008, 32'hCAFE_0001, 1'b0);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        check1("abort_pre_mem_we", mem_we, 1'b1);
        reset = 1'b1;
        #1;
        check1("abort_mem_en_drop", mem_en, 1'b0);
        check1("abort_mem_we_drop", mem_we, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
      end
    join
    check("abort_reserved_store", store[32'h1001_0008], 32'hCAFE_0001);

    // Randomised traffic on both ports
    fork
      for (int i = 0; i < 40; i++) begin
        if_access(rand_if_addr());
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      for (int j = 0; j < 40; j++) begin
        d_access(1'($urandom_range(0, 1)), rand_d_addr(), $urandom, 1'b0);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
    join

    // Saturation: start near the top and keep both ports busy
    cc_chk = 0;
    force dut.conflict_q = 16'hFFFC;
    @(posedge clk); #1;
    release dut.conflict_q;
    fork
      repeat (4) if_access(rand_if_addr());
      repeat (4) d_access(1'b0, rand_d_addr(), 32'h0, 1'b0);
    join
    check("sat_reached", {16'h0, conflict_cnt}, 32'h0000_FFFF);
    fork
      repeat (2) if_access(rand_if_addr());
      repeat (2) d_access(1'b0, rand_d_addr(), 32'h0, 1'b0);
    join
    check("sat_held", {16'h0, conflict_cnt}, 32'h0000_FFFF);

    repeat (3) @(posedge clk);
    check("if_queue_drained", 32'(if_q.size()), 32'd0);
    check("d_queue_drained",  32'(d_q.size()),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
